freq_display: RTL and testbench
===============================

Name: freq_display

Overview:
- Display back end that sits directly downstream of the frequency counter.
- Latches the 16-bit binary count on a gate pulse and converts it to 4-digit BCD with a sequential shift-add-3 engine.
- Time-multiplexes the digits onto the 4-anode, 8-cathode seven-segment display.
- Owns its own scan prescaler, so no separate scan clock is needed.

Parameters:
- SCAN_DIV, 100_000: clk cycles per digit slot; legal range 2..2^20.
- MAX_VAL, 9999: saturation limit; counts above it show MAX_VAL.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- count  input  16  binary count from the counter stage; sampled only when load is accepted.
- load  input  1  single-cycle pulse requesting capture of count.
- anodes  output  4  digit enables, active-low; bit 0 = ones digit (rightmost).
- cathodes  output  8  segments, active-low, order {dp,g,f,e,d,c,b,a}.
- busy  output  1  high while a conversion is in progress.
- overflow  output  1  last accepted count exceeded MAX_VAL.

Behaviour:
- Reset (sync, clk edge with reset=1):
  - anodes=4'b1111, cathodes=8'hFF, busy=0, overflow=0.
  - BCD display register=16'h0000, digit index=0, prescaler=0, FSM=IDLE.
  - Reset mid-conversion aborts it; the display register reverts to 0000.
- FSM states:
  - IDLE:
    - Accepts load only when busy=0.
    - On accept: captures min(count, MAX_VAL) into the shift register, clears the BCD scratch, sets overflow=(count>MAX_VAL), goes to CONV, busy=1 from the next cycle.
  - CONV:
    - 16 iterations, one per clk.
    - Each iteration: add 3 to every scratch nibble >=5, then shift {scratch, bin} left by 1.
    - Iteration counter is 5 bits and wraps to 0 on exit.
  - DONE (1 cycle):
    - Copies the scratch to the display register atomically; busy=0 the following cycle; returns to IDLE.
- Latency: load accepted at edge N → display register valid after edge N+17; busy high for edges N+1..N+17 inclusive.
- The displayed value never shows partial conversion results.
- load while busy=1 is dropped silently (no queue); overflow is unchanged.
- load in the same cycle as DONE is dropped.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 continuously, independent of the FSM.
  - On wrap, digit index increments mod 4 (0→1→2→3→0).
- Outputs registered (1-cycle delay from index/display change):
  - anodes = ~(4'b0001 << idx).
  - cathodes = seg(display nibble[idx]).
  - Segment codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90; any nibble >9 → 8'hBF (dash).
- Overflow indication: while overflow=1, dp (bit 7) is driven low on the ones digit.
- Scanning runs from the first cycle after reset release.

Optional Feature:
- Macro: FREQ_DISPLAY_BLANK_EN.
- Defined: leading-zero blanking.
  - Digits above the most significant non-zero digit drive cathodes=8'hFF while their anode is active.
  - The ones digit is never blanked; value 0 shows "   0".
  - Blanking mask is computed from the display register, so it changes only at DONE.
- Undefined: all four digits are always shown, including leading zeros.

Decomposition:
- Package freq_meter_pkg:
  - seg-code constants SEG_0..SEG_9, SEG_DASH, SEG_OFF.
  - FSM state encoding (IDLE, CONV, DONE).
  - BCD_DIGITS=4, BIN_W=16.
- Sub-module bin2bcd_seq:
  - Contains the FSM, iteration counter, shift/add-3 datapath and saturation.
  - Interface: clk, reset, start, bin[15:0], busy, done, bcd[15:0].
- The top holds the display register, prescaler, scan index, segment decode and blanking.

Test Plan (SCAN_DIV=4 for sim):
- Reset held 3 cycles → anodes=1111, cathodes=FF, busy=0, overflow=0; first scan slot after release shows anodes=1110, cathodes=C0.
- load with count=1234 → busy high exactly 17 cycles; slots for idx 0..3 show cathodes 99, B0, A4, F9 on anodes 1110, 1101, 1011, 0111.
- load with count=12000 → display 9999 (cathodes 90 on all digits); overflow=1; ones digit cathodes=10 (dp low); next load with 5 → overflow=0.
- load 1234, then load 5678 at cycle +5 → second load ignored; display 1234; busy drops at +17.
- load 4321, reset asserted at cycle +8 → busy=0 next cycle; display 0000; a subsequent load 42 completes normally in 17 cycles.
- With FREQ_DISPLAY_BLANK_EN, load 7 → idx 1..3 show cathodes FF, idx 0 shows F8; load 0 → only the ones digit shows C0.

Source files
------------

// File: rtl/freq_display_pkg.sv
// Shared constants for the frequency display: segment codes, converter states, widths.
// Latency: none (package only).
// Backpressure: none (package only).
package freq_meter_pkg;

    localparam int BCD_DIGITS = 4;
    localparam int BIN_W      = 16;

    // Active-low segment codes, bit order {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_0    = 8'hC0;
    localparam logic [7:0] SEG_1    = 8'hF9;
    localparam logic [7:0] SEG_2    = 8'hA4;
    localparam logic [7:0] SEG_3    = 8'hB0;
    localparam logic [7:0] SEG_4    = 8'h99;
    localparam logic [7:0] SEG_5    = 8'h92;
    localparam logic [7:0] SEG_6    = 8'h82;
    localparam logic [7:0] SEG_7    = 8'hF8;
    localparam logic [7:0] SEG_8    = 8'h80;
    localparam logic [7:0] SEG_9    = 8'h90;
    localparam logic [7:0] SEG_DASH = 8'hBF;
    localparam logic [7:0] SEG_OFF  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_t;

    // Map one BCD nibble to its segment pattern; non-decimal nibbles show a dash
    function automatic logic [7:0] seg_encode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/freq_display_if.sv
// Bundle of the counter-side request signals and the display-side outputs.
// Latency: none (wiring only).
// Backpressure: load is dropped by the display while busy is high; no queueing.
interface freq_display_if;
    import freq_meter_pkg::*;

    logic [BIN_W-1:0] count;
    logic             load;
    logic [3:0]       anodes;
    logic [7:0]       cathodes;
    logic             busy;
    logic             overflow;

    // Upstream / bench side: supplies count and load, observes the display
    modport master (
        output count, load,
        input  anodes, cathodes, busy, overflow
    );

    // Display side
    modport slave (
        input  count, load,
        output anodes, cathodes, busy, overflow
    );

endinterface

// File: rtl/freq_display_bin2bcd_seq.sv
// Sequential shift-add-3 binary to 4-digit BCD converter with saturation at MAX_VAL.
// Latency: start accepted at edge N, done asserted for the cycle after edge N+16, bcd valid then.
// Backpressure: start is ignored unless idle; busy covers the whole conversion including DONE.
module bin2bcd_seq
    import freq_meter_pkg::*;
#(
    parameter int MAX_VAL = 9999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd
);

    localparam logic [BIN_W-1:0] MAX_V = BIN_W'(MAX_VAL);

    conv_state_t      state_q, state_nxt;
    logic [4:0]       iter_q;
    logic [BIN_W-1:0] shreg_q;
    logic [15:0]      scratch_q;
    logic [15:0]      scratch_adj;
    logic [BIN_W-1:0] bin_sat;

    assign bin_sat = (bin > MAX_V) ? MAX_V : bin;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_nxt;
    end

    // Next-state: one pass through 16 shift iterations, then a single DONE cycle
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (start) state_nxt = CONV;
            CONV:    if (iter_q == 5'd15) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Add-3 correction on every scratch nibble that would overflow a decimal digit after shifting
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (scratch_q[i*4 +: 4] >= 4'd5)
                scratch_adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
        end
    end

    // Datapath: load saturated value, then shift {scratch, bin} left once per CONV cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q   <= '0;
            scratch_q <= '0;
            iter_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shreg_q   <= bin_sat;
                        scratch_q <= '0;
                        iter_q    <= '0;
                    end
                end
                CONV: begin
                    {scratch_q, shreg_q} <= {scratch_adj, shreg_q} << 1;
                    iter_q <= (iter_q == 5'd15) ? 5'd0 : iter_q + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign bcd = scratch_q;

endmodule

// File: rtl/freq_display.sv
// Latches a binary count, converts it to BCD and scans it onto a 4-digit 7-segment display.
// Latency: display register updated 17 cycles after load; anodes/cathodes follow one cycle later.
// Backpressure: load while busy is dropped. Optional FREQ_DISPLAY_BLANK_EN enables leading-zero blanking.
module freq_display
    import freq_meter_pkg::*;
#(
    parameter int SCAN_DIV = 100_000,
    parameter int MAX_VAL  = 9999
) (
    input  logic          clk,
    input  logic          reset,
    freq_display_if.slave bus
);

    localparam int              PW        = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [BIN_W-1:0] MAX_V    = BIN_W'(MAX_VAL);

    logic          conv_busy;
    logic          conv_done;
    logic [15:0]   conv_bcd;
    logic          accept;
    logic          ovf_q;
    logic [15:0]   disp_q;
    logic [PW-1:0] presc_q;
    logic [1:0]    idx_q;
    logic [3:0]    digit;
    logic [7:0]    seg_nxt;
    logic [3:0]    anodes_q;
    logic [7:0]    cathodes_q;

    assign accept = bus.load && !conv_busy;

    bin2bcd_seq #(.MAX_VAL(MAX_VAL)) u_conv (
        .clk   (clk),
        .reset (reset),
        .start (accept),
        .bin   (bus.count),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Overflow flag follows the last accepted count; display register only takes finished results
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q  <= 1'b0;
            disp_q <= '0;
        end else begin
            if (accept)    ovf_q  <= (bus.count > MAX_V);
            if (conv_done) disp_q <= conv_bcd;
        end
    end

    // Free-running scan prescaler; digit index advances on each wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else if (presc_q == PRESC_MAX) begin
            presc_q <= '0;
            idx_q   <= idx_q + 2'd1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    assign digit = disp_q[{idx_q, 2'b00} +: 4];

`ifdef FREQ_DISPLAY_BLANK_EN
    logic [3:0] blank_mask;
    // A digit is blank when it and every more significant digit are zero; ones digit always shows
    always_comb begin
        blank_mask    = 4'b0000;
        blank_mask[1] = (disp_q[15:4]  == 12'd0);
        blank_mask[2] = (disp_q[15:8]  == 8'd0);
        blank_mask[3] = (disp_q[15:12] == 4'd0);
    end
`endif

    // Segment pattern for the active digit, with blanking and the overflow decimal point
    always_comb begin
        seg_nxt = seg_encode(digit);
`ifdef FREQ_DISPLAY_BLANK_EN
        if (blank_mask[idx_q]) seg_nxt = SEG_OFF;
`endif
        if (ovf_q && (idx_q == 2'd0)) seg_nxt[7] = 1'b0;
    end

    // Registered display drive
    always_ff @(posedge clk) begin
        if (reset) begin
            anodes_q   <= 4'b1111;
            cathodes_q <= SEG_OFF;
        end else begin
            anodes_q   <= ~(4'b0001 << idx_q);
            cathodes_q <= seg_nxt;
        end
    end

    assign bus.anodes   = anodes_q;
    assign bus.cathodes = cathodes_q;
    assign bus.busy     = conv_busy;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_freq_display.sv
// Scoreboard bench for freq_display with SCAN_DIV=4.
// Stimulus pushes expected conversion results; a monitor pops them on each busy pulse.
// Checks busy length, overflow and the cathode pattern seen on each anode slot.
module tb_freq_display;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    freq_display_if bus();

    freq_display #(.SCAN_DIV(4), .MAX_VAL(9999)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0]  blen;
        logic        ovf;
        logic [31:0] cath;   // digit i cathodes at [8*i +: 8]
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   finished = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic exp_t mk(input int blen, input bit ovf,
                                input logic [7:0] d3, input logic [7:0] d2,
                                input logic [7:0] d1, input logic [7:0] d0);
        exp_t e;
        e.blen = 8'(blen);
        e.ovf  = ovf;
        e.cath = {d3, d2, d1, d0};
        return e;
    endfunction

    // Called at a negedge; load is sampled by the following posedge
    task automatic do_load(input logic [15:0] v);
        bus.count = v;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    // Monitor: each busy pulse is one conversion; compare it and the scanned digits that follow
    initial begin
        int         len;
        exp_t       e;
        logic [7:0] got [4];
        forever begin
            @(negedge clk);
            if (bus.busy === 1'b1) begin
                len = 0;
                while (bus.busy === 1'b1 && len < 100) begin
                    len++;
                    @(negedge clk);
                end
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_conversion: got busy pulse of %0d cycles expected none", len);
                end else begin
                    e = sb.pop_front();
                    check("busy_len", 32'(len), 32'(e.blen));
                    check("overflow", 32'(bus.overflow), 32'(e.ovf));
                    for (int i = 0; i < 4; i++) got[i] = 8'hxx;
                    for (int k = 0; k < 20; k++) begin
                        @(negedge clk);
                        case (bus.anodes)
                            4'b1110: got[0] = bus.cathodes;
                            4'b1101: got[1] = bus.cathodes;
                            4'b1011: got[2] = bus.cathodes;
                            4'b0111: got[3] = bus.cathodes;
                            default: ;
                        endcase
                    end
                    for (int i = 0; i < 4; i++)
                        check($sformatf("digit%0d_cathodes", i), 32'(got[i]), 32'(e.cath[8*i +: 8]));
                end
            end
        end
    end

    // Stimulus
    initial begin
        reset     = 1'b1;
        bus.count = '0;
        bus.load  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_anodes",   32'(bus.anodes),   32'h0000000F);
        check("rst_cathodes", 32'(bus.cathodes), 32'h000000FF);
        check("rst_busy",     32'(bus.busy),     32'h0);
        check("rst_overflow", 32'(bus.overflow), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("first_slot_anodes",   32'(bus.anodes),   32'h0000000E);
        check("first_slot_cathodes", 32'(bus.cathodes), 32'h000000C0);
        repeat (4) @(negedge clk);

        // 1234
        sb.push_back(mk(17, 1'b0, 8'hF9, 8'hA4, 8'hB0, 8'h99));
        do_load(16'd1234);
        repeat (45) @(negedge clk);

        // 12000 saturates to 9999 with dp lit on the ones digit
        sb.push_back(mk(17, 1'b1, 8'h90, 8'h90, 8'h90, 8'h10));
        do_load(16'd12000);
        repeat (45) @(negedge clk);

        // 5 clears overflow
        sb.push_back(mk(17, 1'b0, 8'hC0, 8'hC0, 8'hC0, 8'h92));
        do_load(16'd5);
        repeat (45) @(negedge clk);

        // 1234 then 5678 five cycles later: second load dropped
        sb.push_back(mk(17, 1'b0, 8'hF9, 8'hA4, 8'hB0, 8'h99));
        do_load(16'd1234);
        repeat (4) @(negedge clk);
        do_load(16'd5678);
        repeat (45) @(negedge clk);

        // 4321 aborted by reset sampled at edge +8
        sb.push_back(mk(8, 1'b0, 8'hC0, 8'hC0, 8'hC0, 8'hC0));
        do_load(16'd4321);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'h0);
        repeat (45) @(negedge clk);

        // 42 after the abort
        sb.push_back(mk(17, 1'b0, 8'hC0, 8'hC0, 8'h99, 8'hA4));
        do_load(16'd42);
        repeat (45) @(negedge clk);

`ifdef FREQ_DISPLAY_BLANK_EN
        sb.push_back(mk(17, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hF8));
        do_load(16'd7);
        repeat (45) @(negedge clk);

        sb.push_back(mk(17, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hC0));
        do_load(16'd0);
        repeat (45) @(negedge clk);
`endif

        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        finished = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        if (!finished) begin
            failures++;
            $display("FAIL timeout: got no completion expected completion within 200000 time units");
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

endmodule
